// File: rtl/alu_multicycle.sv
// Registered multi-cycle ALU: single-cycle logic/arith/compare ops plus iterative
// shift-add multiply and restoring unsigned divide behind a Start/Ready/Done handshake.
module alu_multicycle #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Start,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic [3:0]       ALUControl,
   output logic             Ready,
   output logic             Done,
   output logic [WIDTH-1:0] ALUResult,
   output logic [WIDTH-1:0] HiResult,
   output logic             Zero,
   output logic             Overflow,
   output logic             DivByZero
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   typedef enum logic [3:0] {
      OP_AND  = 4'b0000,
      OP_OR   = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_XOR  = 4'b0011,
      OP_SUB  = 4'b0100,
      OP_MUL  = 4'b0101,
      OP_SLT  = 4'b0110,
      OP_SLTU = 4'b0111,
      OP_DIVU = 4'b1000,
      OP_NOR  = 4'b1001
   } op_t;

   state_t               state;
   logic [2*WIDTH-1:0]   acc;     // {hi, lo}: product or {remainder, dividend/quotient}
   logic [WIDTH-1:0]     opnd;    // multiplicand or divisor
   logic [CNT_W-1:0]     cnt;

   logic [WIDTH-1:0]     sum;
   logic [WIDTH-1:0]     diff;
   logic [WIDTH-1:0]     sc_result;
   logic                 sc_ovf;
   logic                 sc_legal;

   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH:0]       div_trial;
   logic [2*WIDTH-1:0]   div_next;
   logic                 last;

   assign Ready = (state == S_IDLE) || (state == S_DONE);
   assign Zero  = (ALUResult == '0);
   assign last  = (cnt == CNT_W'(1));

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      sum       = SrcA + SrcB;
      diff      = SrcA - SrcB;
      sc_result = '0;
      sc_ovf    = 1'b0;
      sc_legal  = 1'b1;
      case (ALUControl)
         OP_AND:  sc_result = SrcA & SrcB;
         OP_OR:   sc_result = SrcA | SrcB;
         OP_XOR:  sc_result = SrcA ^ SrcB;
         OP_NOR:  sc_result = ~(SrcA | SrcB);
         OP_ADD: begin
            sc_result = sum;
            sc_ovf    = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);
         end
         OP_SUB: begin
            sc_result = diff;
            sc_ovf    = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (diff[WIDTH-1] != SrcA[WIDTH-1]);
         end
         OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
         OP_MUL, OP_DIVU: sc_result = '0;
         default: sc_legal = 1'b0;
      endcase
   end

   // One iteration of each algorithm; the low half of acc holds the bits still to consume.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      mul_next  = {mul_sum, acc[WIDTH-1:1]};
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_trial = div_shift - {1'b0, opnd};
      div_next  = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge RST) begin
      // NOTE: datapath registers are reset too; Zero and the held results are
      // architecturally visible straight out of reset.
      if (!RST) begin
         state     <= S_IDLE;
         acc       <= '0;
         opnd      <= '0;
         cnt       <= '0;
         ALUResult <= '0;
         HiResult  <= '0;
         Overflow  <= 1'b0;
         DivByZero <= 1'b0;
         Done      <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (Start) begin
                  case (ALUControl)
                     OP_MUL: begin
                        state <= S_MUL;
                        acc   <= {{WIDTH{1'b0}}, SrcB};
                        opnd  <= SrcA;
                        cnt   <= CNT_W'(WIDTH);
                     end
                     OP_DIVU: begin
                        if (SrcB == '0) begin
                           state     <= S_DONE;
                           Done      <= 1'b1;
                           ALUResult <= '1;
                           HiResult  <= SrcA;
                           Overflow  <= 1'b0;
                           DivByZero <= 1'b1;
                        end else begin
                           state <= S_DIV;
                           acc   <= {{WIDTH{1'b0}}, SrcA};
                           opnd  <= SrcB;
                           cnt   <= CNT_W'(WIDTH);
                        end
                     end
                     default: begin
                        // Illegal opcodes still complete so the control FSM never stalls.
                        state     <= S_DONE;
                        Done      <= 1'b1;
                        Overflow  <= sc_ovf;
                        DivByZero <= 1'b0;
                        if (sc_legal) begin
                           ALUResult <= sc_result;
                           HiResult  <= '0;
                        end
                     end
                  endcase
               end else begin
                  state <= S_IDLE;
               end
            end
            S_MUL: begin
               acc <= mul_next;
               cnt <= cnt - 1'b1;
               if (last) begin
                  state     <= S_DONE;
                  Done      <= 1'b1;
                  ALUResult <= mul_next[WIDTH-1:0];
                  HiResult  <= mul_next[2*WIDTH-1:WIDTH];
                  Overflow  <= 1'b0;
                  DivByZero <= 1'b0;
               end
            end
            S_DIV: begin
               acc <= div_next;
               cnt <= cnt - 1'b1;
               if (last) begin
                  state     <= S_DONE;
                  Done      <= 1'b1;
                  ALUResult <= div_next[WIDTH-1:0];
                  HiResult  <= div_next[2*WIDTH-1:WIDTH];
                  Overflow  <= 1'b0;
                  DivByZero <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU, intended for the multi-cycle core variant.
- Logic and add/sub/compare ops complete in one cycle.
- Multiply (full double-width product) and unsigned divide/remainder run iteratively, one bit per clock.
- Controlled by a Start/Ready/Done handshake from the control FSM. Results stay registered until the next accepted operation.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, do not override).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- Start  input  1  request; accepted only when Ready=1.
- SrcA  input  WIDTH  operand A, sampled on accept.
- SrcB  input  WIDTH  operand B, sampled on accept.
- ALUControl  input  4  opcode, sampled on accept.
- Ready  output  1  block can accept Start this cycle.
- Done  output  1  one-cycle pulse: results valid.
- ALUResult  output  WIDTH  primary result / product low / quotient.
- HiResult  output  WIDTH  product high / remainder; 0 for single-cycle ops.
- Zero  output  1  ALUResult == 0.
- Overflow  output  1  signed overflow of ADD/SUB; 0 otherwise.
- DivByZero  output  1  DIVU issued with SrcB == 0.

Behaviour:
- Reset (RST=0, async, any state): state=IDLE; ALUResult, HiResult, Overflow, DivByZero, Done = 0; Zero=1; Ready=1. An operation in flight is discarded.
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0100 SUB, 0110 SLT signed, 0111 SLTU, 0011 XOR, 1001 NOR.
  - 0101 MUL (unsigned, 2*WIDTH product).
  - 1000 DIVU.
  - Others are illegal.
- States: IDLE, MUL, DIV, DONE. Ready = (state==IDLE || state==DONE).
- Accept = Start & Ready. Operands and opcode are latched on the accept edge; later input changes are ignored.
- Single-cycle ops: accept at edge N → results registered at edge N, state=DONE, Done=1 during cycle N+1. Latency 1.
- MUL: accept → state MUL, counter=WIDTH.
  - Shift-add one multiplier bit per clock.
  - After WIDTH cycles in MUL → DONE.
  - Done asserted WIDTH+1 cycles after accept.
  - ALUResult = product[WIDTH-1:0], HiResult = product[2*WIDTH-1:WIDTH].
- DIVU: restoring divide, one quotient bit per clock, same WIDTH+1 latency.
  - ALUResult = quotient, HiResult = remainder.
- DIVU with SrcB==0: no iteration. Goes directly to DONE (latency 1) with ALUResult = all ones, HiResult = SrcA, DivByZero=1.
- SLT/SLTU: ALUResult = {WIDTH-1 zeros, flag}.
- ADD/SUB wrap modulo 2^WIDTH. Overflow = signed overflow (operand signs compared with result sign).
- Illegal opcode: ALUResult and HiResult hold their previous values; flags cleared; Done still pulses (latency 1). The handshake never hangs.
- DONE lasts exactly one cycle.
  - Accept in DONE starts the next op (back-to-back).
  - Otherwise → IDLE.
- Outputs hold their last values in IDLE. Intermediate accumulator values never appear on ALUResult/HiResult. Result registers update only on the completion edge.
- Zero is combinational from registered ALUResult.
- Start while Ready=0 is ignored and not queued.
- Overflow/DivByZero are updated at each completion and held until the next completion.

Test Plan:
- Reset then ADD 0x7FFFFFFF+0x00000001 → Done at cycle+1, ALUResult=0x80000000, Overflow=1, Zero=0, HiResult=0.
- SUB 5−5, then back-to-back SLT 0xFFFFFFFF,0x00000001 issued in the DONE cycle → first ALUResult=0, Zero=1; second ALUResult=1. SLTU on the same operands → 0.
- MUL 0xFFFFFFFF×0x00000002 → Ready=0 for 32 cycles; Done exactly 33 cycles after accept; ALUResult=0xFFFFFFFE, HiResult=0x00000001. Start pulses mid-op are ignored; operand inputs toggled mid-op do not alter the result.
- DIVU 100/7 → Done at +33, ALUResult=14, HiResult=2. DIVU 100/0 → Done at +1, ALUResult=0xFFFFFFFF, HiResult=100, DivByZero=1.
- RST low at cycle 10 of a MUL → all outputs reset immediately (asynchronous), Ready=1, no Done pulse. A new ADD 2+3 after release → 5.
- Illegal opcode 1111 after AND 0xF0F0F0F0&0x0FF00FF0 (=0x00F000F0) → Done pulses, ALUResult stays 0x00F000F0. Repeat the MUL test with WIDTH=8: 0xFF×0x02 → lo 0xFE, hi 0x01, Done at +9.
